// File: rtl/led_seq_pkg.sv
// Shared types and defaults for the LED step sequencer.
// State encoding and default field widths live here so sub-modules agree.
package led_seq_pkg;

    localparam int DEF_WIDTH = 9;
    localparam int DEF_LED_W = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/led_tick_gen.sv
// Tick source for the step timer. With LED_STEP_PRESCALER_EN defined a
// prescaler divides the clock by PRESCALE; otherwise every enabled cycle ticks.
module led_tick_gen #(
    parameter int PRESCALE = 1000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

`ifdef LED_STEP_PRESCALER_EN
    localparam int PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    logic [PW-1:0] pre;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre <= '0;
        end else if (clear) begin
            pre <= '0;
        end else if (enable) begin
            pre <= (pre == PMAX) ? '0 : pre + PW'(1);
        end
    end

    assign tick = enable && (pre == PMAX);
`else
    // Clock, reset, clear and PRESCALE have no role without the prescaler.
    logic tick_unused;
    assign tick_unused = ^{clk, reset_n, clear, (PRESCALE > 1)};
    assign tick        = enable;
`endif

endmodule

// File: rtl/led_step_sequencer.sv
// Microcode-driven LED sequencer: accepts one step in IDLE, holds it for
// delay+1 ticks in RUN. Optional prescaler via LED_STEP_PRESCALER_EN.
module led_step_sequencer
    import led_seq_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int LED_W    = DEF_LED_W,
    parameter int PRESCALE = 1000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             step_valid,
    output logic             step_ready,
    input  logic [LED_W-1:0] step_led,
    input  logic [WIDTH-1:0] step_delay,
    input  logic             step_last,
    output logic [LED_W-1:0] led,
    output logic             busy,
    output logic             seq_done
);

    state_t           state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] dly;
    logic             last;
    logic             tick;
    logic             accept;

    assign step_ready = (state == ST_IDLE);
    assign busy       = (state == ST_RUN);
    assign accept     = step_ready && step_valid;

    led_tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (accept),
        .enable  (busy),
        .tick    (tick)
    );

    // Compare before increment so delay = all-ones expires without wrapping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            led      <= '0;
            cnt      <= '0;
            dly      <= '0;
            last     <= 1'b0;
            seq_done <= 1'b0;
        end else begin
            seq_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (step_valid) begin
                        led   <= step_led;
                        dly   <= step_delay;
                        last  <= step_last;
                        cnt   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (tick) begin
                        if (cnt == dly) begin
                            state    <= ST_IDLE;
                            seq_done <= last;
                        end else begin
                            cnt <= cnt + WIDTH'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_led_step_sequencer.sv
// Directed + randomized bench for led_step_sequencer against a duration model.
module tb_led_step_sequencer;

    localparam int WIDTH    = 4;
    localparam int LED_W    = 8;
    localparam int PRESCALE = 4;
`ifdef LED_STEP_PRESCALER_EN
    localparam int P = PRESCALE;
`else
    localparam int P = 1;
`endif

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             step_valid = 1'b0;
    logic             step_ready;
    logic [LED_W-1:0] step_led = '0;
    logic [WIDTH-1:0] step_delay = '0;
    logic             step_last = 1'b0;
    logic [LED_W-1:0] led;
    logic             busy;
    logic             seq_done;

    int tests = 0;
    int fails = 0;

    led_step_sequencer #(
        .WIDTH    (WIDTH),
        .LED_W    (LED_W),
        .PRESCALE (PRESCALE)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .step_valid (step_valid),
        .step_ready (step_ready),
        .step_led   (step_led),
        .step_delay (step_delay),
        .step_last  (step_last),
        .led        (led),
        .busy       (busy),
        .seq_done   (seq_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Offer one step from an IDLE negedge; returns at the first IDLE negedge
    // after expiry. Expected RUN length is (delay+1)*P cycles.
    task automatic do_step(input logic [7:0] p, input int d, input bit l, input bit keep_valid);
        int run_cycles;
        step_valid = 1'b1;
        step_led   = p;
        step_delay = WIDTH'(d);
        step_last  = l;
        check("ready_before_accept", {31'd0, step_ready}, 32'd1);
        @(posedge clk);
        #1;
        check("led_after_accept", {24'd0, led}, {24'd0, p});
        step_valid = keep_valid;
        step_led   = 8'($urandom);
        step_delay = WIDTH'($urandom);
        step_last  = 1'($urandom);
        run_cycles = 0;
        forever begin
            @(negedge clk);
            if (!busy) break;
            run_cycles++;
            if (led !== p)       check("led_hold_run", {24'd0, led}, {24'd0, p});
            if (seq_done !== 0)  check("done_in_run", {31'd0, seq_done}, 32'd0);
            if (run_cycles > (d + 1) * P + 4) begin
                check("run_timeout", 32'(run_cycles), 32'((d + 1) * P));
                break;
            end
        end
        check("run_length", 32'(run_cycles), 32'((d + 1) * P));
        check("done_pulse", {31'd0, seq_done}, {31'd0, l});
        check("ready_after", {31'd0, step_ready}, 32'd1);
        check("led_after_done", {24'd0, led}, {24'd0, p});
    endtask

    task automatic idle_gap();
        step_valid = 1'b0;
        @(negedge clk);
        check("done_once", {31'd0, seq_done}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [7:0] lastp;
        // Reset and idle
        #12 reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("rst_led", {24'd0, led}, 32'd0);
            check("rst_ready", {31'd0, step_ready}, 32'd1);
            check("rst_busy", {31'd0, busy}, 32'd0);
            check("rst_done", {31'd0, seq_done}, 32'd0);
        end

        // Single step
        do_step(8'hA5, 3, 1'b1, 1'b0);
        idle_gap();

        // Streaming with valid held high; done only after the last
        do_step(8'h01, 0, 1'b0, 1'b1);
        do_step(8'h02, 0, 1'b0, 1'b1);
        do_step(8'h04, 0, 1'b1, 1'b0);
        idle_gap();

        // Maximum delay, no wrap
        do_step(8'h3C, 15, 1'b1, 1'b0);
        idle_gap();

        // Reset mid-RUN
        step_valid = 1'b1;
        step_led   = 8'h77;
        step_delay = WIDTH'(5);
        step_last  = 1'b1;
        @(posedge clk);
        #1 step_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("busy_before_abort", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("abort_led", {24'd0, led}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_ready", {31'd0, step_ready}, 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (seq_done !== 0 || busy !== 0)
                check("post_abort_quiet", {30'd0, seq_done, busy}, 32'd0);
        end
        check("post_abort_done", {31'd0, seq_done}, 32'd0);
        do_step(8'h5A, 2, 1'b1, 1'b0);
        idle_gap();

        // Randomized steps
        lastp = 8'h00;
        for (int i = 0; i < 20; i++) begin
            logic [7:0] p;
            int         d;
            bit         l;
            bit         kv;
            p  = 8'($urandom);
            d  = int'($urandom_range(0, 15));
            l  = 1'($urandom);
            kv = 1'($urandom);
            do_step(p, d, l, kv);
            if (!kv) idle_gap();
            lastp = p;
        end
        step_valid = 1'b0;
        @(negedge clk);
        check("final_led_hold", {24'd0, led}, {24'd0, lastp});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: sim time limit reached");
        $fatal(1, "timeout");
    end

endmodule
